// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment display driver and scan reader.
//   - Segment bit order on the bus: bit0 = a ... bit6 = g.
//   - Active-low patterns for digits 0-9 (0 = segment lit), the blank pattern and
//     the digit code reported for undecodable patterns.
//   - seg7_decode_t: result record produced by the pattern decoder.
package seg7_pkg;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // One-hot masks of the individual segments (active high).
  localparam logic [6:0] MASK_A = 7'(1 << SEG_A);
  localparam logic [6:0] MASK_B = 7'(1 << SEG_B);
  localparam logic [6:0] MASK_C = 7'(1 << SEG_C);
  localparam logic [6:0] MASK_D = 7'(1 << SEG_D);
  localparam logic [6:0] MASK_E = 7'(1 << SEG_E);
  localparam logic [6:0] MASK_F = 7'(1 << SEG_F);
  localparam logic [6:0] MASK_G = 7'(1 << SEG_G);

  // Active-low patterns: built from the lit segments, then inverted.
  localparam logic [6:0] SEG_0 = ~(MASK_A | MASK_B | MASK_C | MASK_D | MASK_E | MASK_F);
  localparam logic [6:0] SEG_1 = ~(MASK_B | MASK_C);
  localparam logic [6:0] SEG_2 = ~(MASK_A | MASK_B | MASK_D | MASK_E | MASK_G);
  localparam logic [6:0] SEG_3 = ~(MASK_A | MASK_B | MASK_C | MASK_D | MASK_G);
  localparam logic [6:0] SEG_4 = ~(MASK_B | MASK_C | MASK_F | MASK_G);
  localparam logic [6:0] SEG_5 = ~(MASK_A | MASK_C | MASK_D | MASK_F | MASK_G);
  localparam logic [6:0] SEG_6 = ~(MASK_A | MASK_C | MASK_D | MASK_E | MASK_F | MASK_G);
  localparam logic [6:0] SEG_7 = ~(MASK_A | MASK_B | MASK_C);
  localparam logic [6:0] SEG_8 = ~(MASK_A | MASK_B | MASK_C | MASK_D | MASK_E | MASK_F | MASK_G);
  localparam logic [6:0] SEG_9 = ~(MASK_A | MASK_B | MASK_C | MASK_D | MASK_F | MASK_G);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] DIGIT_ERR = 4'hF;

  typedef struct packed {
    logic [3:0] digit;
    logic       blank;
    logic       err;
  } seg7_decode_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational decode of one active-low 7-segment pattern.
//   pattern_i  [6:0]  segment pattern, bit0 = a ... bit6 = g, 0 = lit
//   digit_o    [3:0]  decoded digit; 0 for blank, DIGIT_ERR for unknown patterns
//   blank_o           pattern had all segments off
//   err_o             pattern matched neither a digit nor blank
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] digit_o,
  output logic       blank_o,
  output logic       err_o
);

  always_comb begin
    digit_o = DIGIT_ERR;
    blank_o = 1'b0;
    err_o   = 1'b0;
    case (pattern_i)
      SEG_0:     digit_o = 4'd0;
      SEG_1:     digit_o = 4'd1;
      SEG_2:     digit_o = 4'd2;
      SEG_3:     digit_o = 4'd3;
      SEG_4:     digit_o = 4'd4;
      SEG_5:     digit_o = 4'd5;
      SEG_6:     digit_o = 4'd6;
      SEG_7:     digit_o = 4'd7;
      SEG_8:     digit_o = 4'd8;
      SEG_9:     digit_o = 4'd9;
      SEG_BLANK: begin
        digit_o = 4'd0;
        blank_o = 1'b1;
      end
      default: begin
        digit_o = DIGIT_ERR;
        err_o   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: monitors a multiplexed active-low 7-segment bus, rejects glitches,
// decodes each settled pattern and keeps a per-position register image.
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   seg_n [6:0]    segment lines, active low, bit0 = a ... bit6 = g
//   dig_en_n [N]   digit enables, active low, expected one-hot-low
//   clear          synchronous clear of image, seen mask and run counter
//   digits_o [4N]  decoded digit per position, position i in [4i+3:4i]
//   blank_o [N]    position last showed blank
//   err_o [N]      position last showed an undecodable pattern
//   updated_o      one-cycle pulse after a position is committed
//   frame_valid_o  one-cycle pulse when every position has been committed
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_en_n,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   blank_o,
  output logic [NUM_DIGITS-1:0]   err_o,
  output logic                    updated_o,
  output logic                    frame_valid_o
);

  localparam int unsigned SampW = NUM_DIGITS + 7;
  localparam int unsigned CntW  = $clog2(STABLE_CYCLES + 1);

  logic [SampW-1:0]        sample_q, sample_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    updated_q, updated_d;
  logic                    frame_q, frame_d;

  logic                    same;
  logic [NUM_DIGITS-1:0]   en_low;
  logic                    one_hot;
  logic                    run_done;
  logic                    commit;
  logic [NUM_DIGITS-1:0]   seen_next;
  seg7_decode_t            dec;

  assign sample_d = {dig_en_n, seg_n};
  assign same     = (sample_d == sample_q);

  // Enables and segments come from the sample register, which equals the bus
  // value whenever a run completes.
  assign en_low  = ~sample_q[SampW-1:7];
  assign one_hot = (en_low != '0) && ((en_low & (en_low - NUM_DIGITS'(1))) == '0);

  // The run completes on the edge that takes the counter to STABLE_CYCLES; the
  // counter saturates there, so a held value never completes a second time.
  assign run_done = same && (cnt_q == CntW'(STABLE_CYCLES - 1));
  assign commit   = run_done && one_hot && !clear;

  seg7_pattern_decode u_decode (
    .pattern_i (sample_q[6:0]),
    .digit_o   (dec.digit),
    .blank_o   (dec.blank),
    .err_o     (dec.err)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (!same) begin
      cnt_d = CntW'(1);
    end else if (cnt_q != CntW'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_comb begin
    digits_d  = digits_q;
    blank_d   = blank_q;
    err_d     = err_q;
    seen_d    = seen_q;
    seen_next = seen_q | en_low;
    updated_d = commit;
    frame_d   = 1'b0;
    if (clear) begin
      digits_d = '0;
      blank_d  = '1;
      err_d    = '0;
      seen_d   = '0;
    end else if (commit) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (en_low[i]) begin
          digits_d[4*i +: 4] = dec.digit;
          blank_d[i]         = dec.blank;
          err_d[i]           = dec.err;
        end
      end
      // The completing commit starts the next frame from an empty mask.
      if (&seen_next) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d = seen_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_q  <= '1;
      cnt_q     <= '0;
      digits_q  <= '0;
      blank_q   <= '1;
      err_q     <= '0;
      seen_q    <= '0;
      updated_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      sample_q  <= sample_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      blank_q   <= blank_d;
      err_q     <= err_d;
      seen_q    <= seen_d;
      updated_q <= updated_d;
      frame_q   <= frame_d;
    end
  end

  assign digits_o      = digits_q;
  assign blank_o       = blank_q;
  assign err_o         = err_q;
  assign updated_o     = updated_q;
  assign frame_valid_o = frame_q;

endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Receive-side counterpart of the team's 7-segment display driver: monitors a time-multiplexed, active-low 7-segment bus (segment lines plus per-digit enables), filters glitches, decodes each settled pattern back to a 4-bit digit and assembles a per-digit register image. It sits in self-check and loopback designs, between the display-driving logic and any consumer needing the displayed value as data, e.g. a checker or bus readback.

## Interface
- NUM_DIGITS, 8, number of multiplexed digit positions (1–8)
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted (≥2)
- clk  input  1  single system clock; everything is on the rising edge
- rst_n  input  1  reset, synchronous and active-low
- seg_n  input  7  segment lines, active low (0 = lit), bit0=a … bit6=g
- dig_en_n  input  NUM_DIGITS  digit enables, active low, expected one-hot-low
- clear  input  1  synchronous clear of the captured image and frame tracking
- digits_o  output  4*NUM_DIGITS  decoded digit per position, position i in bits [4i+3:4i]
- blank_o  output  NUM_DIGITS  position i last showed all segments off
- err_o  output  NUM_DIGITS  position i last showed an undecodable pattern
- updated_o  output  1  one-cycle pulse after any position is committed
- frame_valid_o  output  1  one-cycle pulse when every position has been committed since the last frame

## Operation
- Decode table (seg_n, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; 1111111 = blank (digit 0, blank bit set); anything else = error (digit 4'hF, err bit set).
- Sample register captures {dig_en_n, seg_n} every cycle; run counter: sample equals previous → saturating increment, else → 1.
- Commit: counter reaches STABLE_CYCLES and the sample has exactly one enable low → write decoded digit, blank and err bits into that position. One commit per stable run; holding the same value does not re-commit.
- No enable low, or more than one low → never committed; counter still runs.
- Seen mask: commit sets bit i. When a commit completes the mask (all ones), frame_valid_o pulses and the mask clears to zero, so the completing commit does not count toward the next frame.
- clear: digits_o, blank_o, err_o, seen mask and run counter go to reset values; clear has priority over a coincident commit.

## Timing
- Reset values: digits_o all 0, blank_o all 1, err_o all 0, updated_o 0, frame_valid_o 0, seen mask 0, counter 0, sample register all ones.
- Input value first sampled at edge k → digits_o/blank_o/err_o change at edge k+STABLE_CYCLES−1; updated_o high for the cycle following that edge.
- frame_valid_o is coincident with the updated_o pulse of the completing commit.
- Input change before the run completes → counter restarts and nothing is committed (glitch rejection).
- Reset or clear mid-run → run discarded; the next run restarts at 1.

## Structure
- Package seg7_pkg: active-low pattern constants for 0–9, SEG_BLANK = 7'h7F, DIGIT_ERR = 4'hF, segment bit-order constants; the driver and this block share it.
- Sub-module seg7_pattern_decode: combinational 7-bit pattern → {digit[3:0], blank, err}; instantiated once on the sample register.

## Test plan
- Reset, then drive dig_en_n=8'hFE, seg_n=7'b0100100 for 4 cycles → digits_o[3:0]=2, blank_o[0]=0, err_o[0]=0, one updated_o pulse.
- Scan positions 0–7 with digits 7,6,…,0, 4 cycles each → digits_o=32'h0123_4567 and a single frame_valid_o on the position-7 commit.
- Pattern held for 3 cycles, then changed → no commit; held 40 cycles → exactly one updated_o.
- seg_n=7'b1111111 on position 3 → blank_o[3]=1, digit 0; seg_n=7'b0101010 → err_o[3]=1, digit 4'hF.
- dig_en_n=8'hFC (two low) or 8'hFF for 10 cycles → no updated_o; image unchanged.
- clear asserted in the same cycle as a commit → outputs at reset values, no updated_o; rst_n low mid-scan → all outputs at reset values on the next edge.
